// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: request side (in_*) and result side (out_*).
`timescale 1ns/1ps
interface seq_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] C_hi;
  logic             div_zero;

  modport master (
    output in_valid, A, B, ALUOp, out_ready,
    input  in_ready, out_valid, C, C_hi, div_zero
  );

  modport slave (
    input  in_valid, A, B, ALUOp, out_ready,
    output in_ready, out_valid, C, C_hi, div_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/shift plus iterative unsigned multiply/divide.
// Define SEQ_ALU_EARLY_OUT_EN to let MUL/DIV finish as soon as the remaining operand bits are zero.
`timescale 1ns/1ps
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [SHW-1:0] ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   c_r;
  logic [WIDTH-1:0]   c_hi_r;
  logic               dz_r;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplr_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   dvd_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic               mul_early;
  logic               div_early;

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic [SHW-1:0]          sh;
    a_s = a;
    sh  = b[SHW-1:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a >> sh;
      4'd5:    return a_s >>> sh;
      4'd6:    return a ^ b;
      4'd7:    return a << sh;
      default: return '0;
    endcase
  endfunction

  // One shift-add multiply step and one restoring-divide step per cycle.
  always_comb begin
    acc_nxt       = mplr[0] ? acc + mcand : acc;
    mplr_nxt      = mplr >> 1;
    rem_sh        = {rem, dvd[WIDTH-1]};
    rem_sub       = rem_sh - {1'b0, b_r};
    q_bit         = ~rem_sub[WIDTH];
    rem_nxt       = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nxt       = dvd << 1;
    quo_nxt       = quo;
    quo_nxt[cnt]  = q_bit;
  end

`ifdef SEQ_ALU_EARLY_OUT_EN
  // A zero remainder with no dividend bits left means every remaining quotient bit is zero.
  assign mul_early = (mplr_nxt == '0);
  assign div_early = (dvd_nxt == '0) && (rem_nxt == '0);
`else
  assign mul_early = 1'b0;
  assign div_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      b_r    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      rem    <= '0;
      dvd    <= '0;
      quo    <= '0;
      c_r    <= '0;
      c_hi_r <= '0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dz_r  <= 1'b0;
          cnt   <= '1;
          b_r   <= bus.B;
          acc   <= '0;
          mcand <= {{WIDTH{1'b0}}, bus.A};
          mplr  <= bus.B;
          rem   <= '0;
          dvd   <= bus.A;
          quo   <= '0;
          case (bus.ALUOp)
            4'd8:    state <= MUL;
            4'd9:    state <= DIV;
            default: begin
              state  <= DONE;
              c_r    <= alu_op(bus.ALUOp, bus.A, bus.B);
              c_hi_r <= '0;
            end
          endcase
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr_nxt;
          cnt   <= cnt - ONE;
          if (cnt == '0 || mul_early) begin
            state  <= DONE;
            c_r    <= acc_nxt[WIDTH-1:0];
            c_hi_r <= acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        DIV: begin
`ifdef SEQ_ALU_EARLY_OUT_EN
          // dvd still holds A on the first DIV cycle, which is the divide-by-zero remainder.
          if (b_r == '0) begin
            state  <= DONE;
            c_r    <= '1;
            c_hi_r <= dvd;
            dz_r   <= 1'b1;
          end else
`endif
          begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            quo <= quo_nxt;
            cnt <= cnt - ONE;
            if (cnt == '0 || div_early) begin
              state  <= DONE;
              c_r    <= quo_nxt;
              c_hi_r <= rem_nxt;
              dz_r   <= (b_r == '0);
            end
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.C         = c_r;
  assign bus.C_hi      = c_hi_r;
  assign bus.div_zero  = dz_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): reset, single-cycle ops, multiply, divide, back-pressure.
`timescale 1ns/1ps
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_alu_if #(.WIDTH(32)) bus ();
  seq_alu #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present one op from IDLE; lat counts cycles from the accept edge until out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output int lat, output logic [31:0] c, output logic [31:0] chi,
                       output logic dz);
    bus.A = a; bus.B = b; bus.ALUOp = op; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    c = bus.C; chi = bus.C_hi; dz = bus.div_zero;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.A = '0; bus.B = '0; bus.ALUOp = '0;
    reset_n = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.C !== 32'h0) begin errors++; $display("FAIL reset C: got %h expected 0", bus.C); end
    checks++; if (bus.C_hi !== 32'h0) begin errors++; $display("FAIL reset C_hi: got %h expected 0", bus.C_hi); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset div_zero: got %b expected 0", bus.div_zero); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [31:0] va[11], vb[11], ve[11];
    logic [3:0]  vo[11];
    int lat; logic [31:0] c, chi; logic dz;
    va[0]  = 32'hFFFF_FFFF; vb[0]  = 32'h1;         vo[0]  = 4'd0; ve[0]  = 32'h0;
    va[1]  = 32'h5;         vb[1]  = 32'h7;         vo[1]  = 4'd1; ve[1]  = 32'hFFFF_FFFE;
    va[2]  = 32'hF0F0_F0F0; vb[2]  = 32'hFF00_FF00; vo[2]  = 4'd2; ve[2]  = 32'hF000_F000;
    va[3]  = 32'hF0F0_F0F0; vb[3]  = 32'h0F0F_0000; vo[3]  = 4'd3; ve[3]  = 32'hFFFF_F0F0;
    va[4]  = 32'h8000_0000; vb[4]  = 32'h4;         vo[4]  = 4'd4; ve[4]  = 32'h0800_0000;
    va[5]  = 32'h8000_0000; vb[5]  = 32'd33;        vo[5]  = 4'd5; ve[5]  = 32'hC000_0000;
    va[6]  = 32'hAAAA_AAAA; vb[6]  = 32'hFFFF_0000; vo[6]  = 4'd6; ve[6]  = 32'h5555_AAAA;
    va[7]  = 32'h1;         vb[7]  = 32'd31;        vo[7]  = 4'd7; ve[7]  = 32'h8000_0000;
    va[8]  = 32'h3;         vb[8]  = 32'd33;        vo[8]  = 4'd7; ve[8]  = 32'h6;
    va[9]  = 32'h7FFF_FFFF; vb[9]  = 32'h4;         vo[9]  = 4'd5; ve[9]  = 32'h07FF_FFFF;
    va[10] = 32'hFFFF_FFFF; vb[10] = 32'hFFFF_FFFF; vo[10] = 4'd0; ve[10] = 32'hFFFF_FFFE;
    for (int i = 0; i < 11; i++) begin
      do_op(va[i], vb[i], vo[i], lat, c, chi, dz);
      checks++; if (c !== ve[i]) begin errors++; $display("FAIL single[%0d] C: got %h expected %h", i, c, ve[i]); end
      checks++; if (chi !== 32'h0) begin errors++; $display("FAIL single[%0d] C_hi: got %h expected 0", i, chi); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL single[%0d] latency: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF; bus.ALUOp = 4'd8; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.C !== 32'h0) begin errors++; $display("FAIL midreset C: got %h expected 0", bus.C); end
    checks++; if (bus.C_hi !== 32'h0) begin errors++; $display("FAIL midreset C_hi: got %h expected 0", bus.C_hi); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset stray result: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_mul();
    logic [31:0] va[4], vb[4], elo[4], ehi[4];
    int el[4];
    int lat; logic [31:0] c, chi; logic dz;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ehi[0] = 32'hFFFF_FFFE; elo[0] = 32'h1;
    va[1] = 32'h3;         vb[1] = 32'h2;         ehi[1] = 32'h0;         elo[1] = 32'h6;
    va[2] = 32'h0001_0000; vb[2] = 32'h0001_0000; ehi[2] = 32'h1;         elo[2] = 32'h0;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'h2;         ehi[3] = 32'h1;         elo[3] = 32'hFFFF_FFFE;
`ifdef SEQ_ALU_EARLY_OUT_EN
    el[0] = 33; el[1] = 3; el[2] = 18; el[3] = 3;
`else
    el[0] = 33; el[1] = 33; el[2] = 33; el[3] = 33;
`endif
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 4'd8, lat, c, chi, dz);
      checks++; if (c !== elo[i]) begin errors++; $display("FAIL mul[%0d] C: got %h expected %h", i, c, elo[i]); end
      checks++; if (chi !== ehi[i]) begin errors++; $display("FAIL mul[%0d] C_hi: got %h expected %h", i, chi, ehi[i]); end
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL mul[%0d] latency: got %0d expected %0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] va[5], vb[5], eq[5], er[5];
    logic        ez[5];
    int el[5];
    int lat; logic [31:0] c, chi; logic dz;
    va[0] = 32'd100;       vb[0] = 32'd7;  eq[0] = 32'd14;        er[0] = 32'd2; ez[0] = 1'b0;
    va[1] = 32'd5;         vb[1] = 32'd0;  eq[1] = 32'hFFFF_FFFF; er[1] = 32'd5; ez[1] = 1'b1;
    va[2] = 32'h8000_0000; vb[2] = 32'd1;  eq[2] = 32'h8000_0000; er[2] = 32'd0; ez[2] = 1'b0;
    va[3] = 32'd7;         vb[3] = 32'd7;  eq[3] = 32'd1;         er[3] = 32'd0; ez[3] = 1'b0;
    va[4] = 32'hFFFF_FFFF; vb[4] = 32'd16; eq[4] = 32'h0FFF_FFFF; er[4] = 32'hF; ez[4] = 1'b0;
`ifdef SEQ_ALU_EARLY_OUT_EN
    el[0] = 33; el[1] = 2; el[2] = 2; el[3] = 33; el[4] = 33;
`else
    el[0] = 33; el[1] = 33; el[2] = 33; el[3] = 33; el[4] = 33;
`endif
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], 4'd9, lat, c, chi, dz);
      checks++; if (c !== eq[i]) begin errors++; $display("FAIL div[%0d] C: got %h expected %h", i, c, eq[i]); end
      checks++; if (chi !== er[i]) begin errors++; $display("FAIL div[%0d] C_hi: got %h expected %h", i, chi, er[i]); end
      checks++; if (dz !== ez[i]) begin errors++; $display("FAIL div[%0d] div_zero: got %b expected %b", i, dz, ez[i]); end
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] c, chi; logic dz;
    do_op(32'd5, 32'd3, 4'd12, lat, c, chi, dz);
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL illegal C: got %h expected 0", c); end
    checks++; if (chi !== 32'h0) begin errors++; $display("FAIL illegal C_hi: got %h expected 0", chi); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal latency: got %0d expected 1", lat); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] c, chi; logic dz;
    bus.out_ready = 1'b0;
    do_op(32'h1234_5678, 32'hFFFF_FFFF, 4'd6, lat, c, chi, dz);
    checks++; if (c !== 32'hEDCB_A987) begin errors++; $display("FAIL bp C: got %h expected edcba987", c); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.C !== 32'hEDCB_A987) begin errors++; $display("FAIL bp hold[%0d] C: got %h expected edcba987", i, bus.C); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp hold[%0d] in_ready: got %b expected 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp hold[%0d] out_valid: got %b expected 1", i, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp release out_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.C !== 32'hEDCB_A987) begin errors++; $display("FAIL idle retain C: got %h expected edcba987", bus.C); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_mul();
    test_mul();
    test_div();
    test_illegal();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor of the single-cycle datapath ALU.
- Adds XOR, SLL and iterative unsigned multiply/divide to the add/sub/logic/shift set, with configurable datapath width.
- Sits between the operand-fetch stage and the writeback register.
- Valid/ready on both sides, so the pipeline stalls while a multi-cycle operation runs.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUOp  input  4  operation select
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer takes the result
- C  output  WIDTH  primary result (product low half / quotient)
- C_hi  output  WIDTH  product high half / remainder; 0 for single-cycle ops
- div_zero  output  1  last result was a divide with B == 0

Behaviour:
- Reset values (asynchronous, on reset_n low, regardless of clk): state=IDLE; C, C_hi, div_zero, out_valid = 0; all internal counters and accumulators = 0.
- Reset asserted mid-operation aborts the operation; no result is produced after release.
- in_ready = (state == IDLE). An operation is accepted on the rising edge where in_valid && in_ready; A, B and ALUOp are captured internally on that edge.
- FSM states and transitions:
  - IDLE: ALUOp 0–7 accepted → DONE. ALUOp 8 → MUL. ALUOp 9 → DIV. ALUOp 10–15 → DONE with C = C_hi = 0.
  - MUL/DIV: iteration counter runs WIDTH cycles (WIDTH-1 down to 0), then → DONE.
  - DONE: out_valid = 1. If out_ready → IDLE, else hold in DONE.
- Latency: single-cycle ops → out_valid 1 cycle after accept; MUL/DIV → out_valid WIDTH+1 cycles after accept.
- No back-to-back accept: at least one IDLE cycle between results.
- In DONE, C, C_hi and div_zero are stable until the handshake completes. C/C_hi retain their last value in IDLE.
- Opcodes (all arithmetic modulo 2^WIDTH, carry/overflow discarded):
  - 0 A+B
  - 1 A−B
  - 2 A&B
  - 3 A|B
  - 4 logical A>>B[SHW-1:0]
  - 5 arithmetic (signed) A>>>B[SHW-1:0]
  - 6 A^B
  - 7 A<<B[SHW-1:0]
  - 8 unsigned multiply, shift-add, one bit per cycle; {C_hi, C} = full 2·WIDTH product
  - 9 unsigned restoring divide, one bit per cycle; C = quotient, C_hi = remainder
- Shift amounts use only the low SHW bits of B; upper bits of B are ignored (e.g. B=33 with WIDTH=32 shifts by 1).
- Divide by zero: C = all ones, C_hi = A, div_zero = 1. The full WIDTH iteration cycles still elapse, so latency is unchanged.
- div_zero is cleared on every accepted operation and set only as above.
- out_ready while out_valid is low is ignored. in_valid while in_ready is low is ignored; the upstream stage holds its operands.

Optional Feature:
- Macro: SEQ_ALU_EARLY_OUT_EN.
- Defined: MUL and DIV finish early when the remaining unprocessed multiplier bits (MUL) or the remaining dividend bits (DIV) are all zero. The FSM enters DONE the cycle after this is detected. Results are identical to full iteration; latency is anywhere from 2 to WIDTH+1 cycles. Divide by zero always takes the fast path: DONE 2 cycles after accept.
- Not defined: fixed WIDTH+1 latency for MUL/DIV, and the early-exit comparator logic is absent.

Test Plan:
- Reset mid-multiply: reset_n low 3 cycles after accepting ALUOp=8 → out_valid, C, C_hi read 0 immediately; in_ready = 1 after release; no result appears.
- Single-cycle ops (WIDTH=32), out_ready tied high:
  - A=32'hFFFF_FFFF, B=1, ALUOp=0 → C = 0, one cycle after accept.
  - A=32'h8000_0000, B=33, ALUOp=5 → C = 32'hC000_0000.
- Multiply: A=32'hFFFF_FFFF, B=32'hFFFF_FFFF, ALUOp=8 → out_valid exactly 33 cycles after accept (without macro); C_hi = 32'hFFFF_FFFE, C = 32'h0000_0001.
- Divide: A=100, B=7, ALUOp=9 → C = 14, C_hi = 2, div_zero = 0. Then A=5, B=0 → C = 32'hFFFF_FFFF, C_hi = 5, div_zero = 1.
- Back-pressure: out_ready low for 5 cycles after out_valid → C stable, in_ready = 0 throughout; out_ready high → IDLE next cycle, in_ready = 1.
- Illegal opcode / early-out: ALUOp=12 → C = 0, C_hi = 0 after 1 cycle. With SEQ_ALU_EARLY_OUT_EN: A=3, B=2, ALUOp=8 → C = 6, out_valid well before cycle 33.
